// File: rtl/segre_mmu_arbiter.sv
// Miss arbiter between NUM_PORTS cache requesters and a single memory port.
// Each port posts a miss (with an optional dirty victim); the arbiter serves one
// pending port at a time by round-robin: optional victim writeback, lane read,
// then a one-cycle refill response back to the granted port.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   miss_i/miss_addr_i           per-port miss pulse and byte address
//   wb_i/wb_addr_i/wb_data_i     per-port dirty victim, sampled with miss_i
//   busy_o                       miss pending for the port
//   rdy_o/data_o/addr_o          one-cycle refill valid, lane and lane address
//   mm_rd_req_o/mm_wr_req_o      memory read/write request pulses
//   mm_addr_o/mm_data_o          memory lane address and write data
//   mm_data_rdy_i/mm_data_i      memory done pulse and read data
module segre_mmu_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned LANE_SIZE = 128
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PORTS-1:0]           miss_i,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0] miss_addr_i,
    input  logic [NUM_PORTS-1:0]           wb_i,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0] wb_addr_i,
    input  logic [NUM_PORTS*LANE_SIZE-1:0] wb_data_i,
    output logic [NUM_PORTS-1:0]           busy_o,
    output logic [NUM_PORTS-1:0]           rdy_o,
    output logic [LANE_SIZE-1:0]           data_o,
    output logic [ADDR_SIZE-1:0]           addr_o,
    output logic                           mm_rd_req_o,
    output logic                           mm_wr_req_o,
    output logic [ADDR_SIZE-1:0]           mm_addr_o,
    output logic [LANE_SIZE-1:0]           mm_data_o,
    input  logic                           mm_data_rdy_i,
    input  logic [LANE_SIZE-1:0]           mm_data_i
);

    localparam int unsigned ByteBits = $clog2(LANE_SIZE / 8);
    localparam int unsigned PtrW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_SIZE-1:0] LaneMask = {{(ADDR_SIZE - ByteBits){1'b1}},
                                                 {ByteBits{1'b0}}};
    // Pointing at the last port makes port 0 the first candidate after reset.
    localparam logic [PtrW-1:0] LastInit = PtrW'(NUM_PORTS - 1);

    typedef enum logic [2:0] {
        StIdle, StWbReq, StWbWait, StRdReq, StRdWait, StResp
    } state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        grant_q, grant_d;
    logic [PtrW-1:0]        last_q, last_d;
    logic [LANE_SIZE-1:0]   rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]   busy_q;
    logic [NUM_PORTS-1:0]   wb_q;
    logic [ADDR_SIZE-1:0]   miss_addr_q [NUM_PORTS];
    logic [ADDR_SIZE-1:0]   wb_addr_q   [NUM_PORTS];
    logic [LANE_SIZE-1:0]   wb_data_q   [NUM_PORTS];

    logic                   found;
    logic [PtrW-1:0]        pick;
    logic [PtrW-1:0]        idx;

    // Round-robin search starting just after the last granted port.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = PtrW'((32'(last_q) + i) % NUM_PORTS);
            if (!found && busy_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    state_d = wb_q[pick] ? StWbReq : StRdReq;
                end
            end
            StWbReq:  state_d = StWbWait;
            StWbWait: if (mm_data_rdy_i) state_d = StRdReq;
            StRdReq:  state_d = StRdWait;
            StRdWait: begin
                if (mm_data_rdy_i) begin
                    rdata_d = mm_data_i;
                    state_d = StResp;
                end
            end
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are forced to zero while reset is asserted, not only after the edge.
    always_comb begin
        busy_o      = rst_i ? '0 : busy_q;
        rdy_o       = '0;
        data_o      = '0;
        addr_o      = '0;
        mm_rd_req_o = 1'b0;
        mm_wr_req_o = 1'b0;
        mm_addr_o   = '0;
        mm_data_o   = '0;
        if (!rst_i) begin
            case (state_q)
                StWbReq: begin
                    mm_wr_req_o = 1'b1;
                    mm_addr_o   = wb_addr_q[grant_q];
                    mm_data_o   = wb_data_q[grant_q];
                end
                StRdReq: begin
                    mm_rd_req_o = 1'b1;
                    mm_addr_o   = miss_addr_q[grant_q];
                end
                StResp: begin
                    rdy_o[grant_q] = 1'b1;
                    data_o         = rdata_q;
                    addr_o         = miss_addr_q[grant_q];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= LastInit;
            rdata_q <= '0;
            busy_q  <= '0;
            wb_q    <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                miss_addr_q[p] <= '0;
                wb_addr_q[p]   <= '0;
                wb_data_q[p]   <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                // A busy port cannot capture, and only a busy port can be in RESP,
                // so capture and release never collide on the same port.
                if (miss_i[p] && !busy_q[p]) begin
                    busy_q[p]      <= 1'b1;
                    miss_addr_q[p] <= miss_addr_i[p*ADDR_SIZE +: ADDR_SIZE] & LaneMask;
                    wb_q[p]        <= wb_i[p];
                    wb_addr_q[p]   <= wb_addr_i[p*ADDR_SIZE +: ADDR_SIZE] & LaneMask;
                    wb_data_q[p]   <= wb_data_i[p*LANE_SIZE +: LANE_SIZE];
                end else if (state_q == StResp && 32'(grant_q) == p) begin
                    busy_q[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_segre_mmu_arbiter.sv
// Bench for segre_mmu_arbiter: directed reset/latency/busy-ignore/abort steps,
// then a randomized phase checked against a transaction schedule built from the
// arbitration rules (round-robin pick, writeback-then-read, fixed phase lengths).
module tb_segre_mmu_arbiter;

    localparam int NP   = 2;
    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int NCYC = 1500;
    localparam int MAXC = NCYC + 64;
    localparam logic [AW-1:0] LANE_MASK = 32'hFFFF_FFF0;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [NP-1:0]   miss_i;
    logic [NP*AW-1:0] miss_addr_i;
    logic [NP-1:0]   wb_i;
    logic [NP*AW-1:0] wb_addr_i;
    logic [NP*LW-1:0] wb_data_i;
    logic [NP-1:0]   busy_o;
    logic [NP-1:0]   rdy_o;
    logic [LW-1:0]   data_o;
    logic [AW-1:0]   addr_o;
    logic            mm_rd_req_o;
    logic            mm_wr_req_o;
    logic [AW-1:0]   mm_addr_o;
    logic [LW-1:0]   mm_data_o;
    logic            mm_data_rdy_i;
    logic [LW-1:0]   mm_data_i;

    int checks = 0;
    int errors = 0;

    // Schedule of expected behaviour, indexed by cycle of the randomized phase.
    logic            exp_wr   [MAXC];
    logic            exp_rd   [MAXC];
    logic            nostray  [MAXC];
    logic            drv_rdy  [MAXC];
    logic [AW-1:0]   exp_maddr[MAXC];
    logic [AW-1:0]   exp_raddr[MAXC];
    logic [LW-1:0]   exp_mdata[MAXC];
    logic [LW-1:0]   exp_rdata[MAXC];
    logic [LW-1:0]   drv_data [MAXC];
    int              exp_resp [MAXC];

    // Per-port captured miss as the model sees it.
    logic            m_busy [NP];
    logic            m_wb   [NP];
    logic [AW-1:0]   m_addr [NP];
    logic [AW-1:0]   m_waddr[NP];
    logic [LW-1:0]   m_wdata[NP];
    int              m_last;
    int              free_at;

    segre_mmu_arbiter #(
        .NUM_PORTS(NP),
        .ADDR_SIZE(AW),
        .LANE_SIZE(LW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .miss_i       (miss_i),
        .miss_addr_i  (miss_addr_i),
        .wb_i         (wb_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .busy_o       (busy_o),
        .rdy_o        (rdy_o),
        .data_o       (data_o),
        .addr_o       (addr_o),
        .mm_rd_req_o  (mm_rd_req_o),
        .mm_wr_req_o  (mm_wr_req_o),
        .mm_addr_o    (mm_addr_o),
        .mm_data_o    (mm_data_o),
        .mm_data_rdy_i(mm_data_rdy_i),
        .mm_data_i    (mm_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [LW-1:0] d1;
        logic [NP-1:0] mb;
        logic [NP-1:0] er;
        int            pick;
        int            c;
        int            d;

        rst_i = 1'b1;
        miss_i = '0;
        miss_addr_i = '0;
        wb_i = '0;
        wb_addr_i = '0;
        wb_data_i = '0;
        mm_data_rdy_i = 1'b0;
        mm_data_i = '0;

        // Reset: outputs zero, misses and memory pulses ignored.
        tick();
        miss_i = '1;
        mm_data_rdy_i = 1'b1;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_rdy", rdy_o, 0);
        chk("rst_rd", mm_rd_req_o, 0);
        chk("rst_wr", mm_wr_req_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_mm_addr", mm_addr_o, 0);
        chk("rst_mm_data", mm_data_o, 0);
        tick();
        chk("rst_busy2", busy_o, 0);
        rst_i = 1'b0;
        miss_i = '0;
        mm_data_rdy_i = 1'b0;
        tick();
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_rd", mm_rd_req_o, 0);

        // Minimum-latency read for port 0, address bits below the lane dropped.
        miss_i = 2'b01;
        miss_addr_i = {32'h0, 32'h0000_1234};
        tick();                                     // t+1
        chk("lat_busy", busy_o, 2'b01);
        miss_i = '0;
        miss_addr_i = {32'hFFFF_FFFF, 32'hDEAD_BEEF};
        tick();                                     // t+2
        chk("lat_rd", mm_rd_req_o, 1);
        chk("lat_wr", mm_wr_req_o, 0);
        chk("lat_mm_addr", mm_addr_o, 32'h0000_1230);
        tick();                                     // t+3
        chk("lat_rd_off", mm_rd_req_o, 0);
        d1 = rnd128();
        mm_data_rdy_i = 1'b1;
        mm_data_i = d1;
        tick();                                     // t+4
        chk("lat_rdy", rdy_o, 2'b01);
        chk("lat_addr", addr_o, 32'h0000_1230);
        chk("lat_data", data_o, d1);
        mm_data_rdy_i = 1'b0;
        tick();
        chk("lat_rdy_off", rdy_o, 0);
        chk("lat_busy_off", busy_o, 0);

        // Second miss on a busy port must not replace the first address.
        miss_i = 2'b10;
        miss_addr_i = {32'h0000_0500, 32'h0};
        tick();
        chk("ign_busy", busy_o, 2'b10);
        miss_addr_i = {32'h0000_0900, 32'h0};
        tick();
        miss_i = '0;
        chk("ign_rd", mm_rd_req_o, 1);
        chk("ign_mm_addr", mm_addr_o, 32'h0000_0500);
        tick();
        d1 = rnd128();
        mm_data_rdy_i = 1'b1;
        mm_data_i = d1;
        tick();
        chk("ign_rdy", rdy_o, 2'b10);
        chk("ign_addr", addr_o, 32'h0000_0500);
        chk("ign_data", data_o, d1);
        mm_data_rdy_i = 1'b0;
        tick();
        chk("ign_busy_off", busy_o, 0);

        // Reset during the read wait abandons the transaction.
        miss_i = 2'b01;
        miss_addr_i = {32'h0, 32'h0000_2000};
        tick();
        miss_i = '0;
        tick();
        chk("abt_rd", mm_rd_req_o, 1);
        tick();                                     // read wait
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mm_data_rdy_i = 1'b1;
        mm_data_i = rnd128();
        #1;
        chk("abt_busy", busy_o, 0);
        chk("abt_rd_off", mm_rd_req_o, 0);
        tick();
        chk("abt_rdy", rdy_o, 0);
        chk("abt_busy2", busy_o, 0);
        mm_data_rdy_i = 1'b0;
        tick();
        chk("abt_rdy2", rdy_o, 0);
        chk("abt_idle_rd", mm_rd_req_o, 0);
        chk("abt_idle_wr", mm_wr_req_o, 0);

        // Randomized phase; the arbiter is idle with port 0 first in line.
        for (int i = 0; i < MAXC; i++) begin
            exp_wr[i] = 1'b0;
            exp_rd[i] = 1'b0;
            nostray[i] = 1'b0;
            drv_rdy[i] = 1'b0;
            exp_maddr[i] = '0;
            exp_raddr[i] = '0;
            exp_mdata[i] = '0;
            exp_rdata[i] = '0;
            drv_data[i] = '0;
            exp_resp[i] = -1;
        end
        for (int p = 0; p < NP; p++) begin
            m_busy[p] = 1'b0;
            m_wb[p] = 1'b0;
            m_addr[p] = '0;
            m_waddr[p] = '0;
            m_wdata[p] = '0;
        end
        m_last = NP - 1;
        free_at = 0;

        for (int k = 0; k < NCYC; k++) begin
            if (k > 0) begin
                tick();
                // Inputs still hold what the DUT sampled at the edge just passed.
                for (int p = 0; p < NP; p++) begin
                    if (miss_i[p] && !m_busy[p]) begin
                        m_busy[p]  = 1'b1;
                        m_addr[p]  = miss_addr_i[p*AW +: AW] & LANE_MASK;
                        m_wb[p]    = wb_i[p];
                        m_waddr[p] = wb_addr_i[p*AW +: AW] & LANE_MASK;
                        m_wdata[p] = wb_data_i[p*LW +: LW];
                    end else if (exp_resp[k-1] == p) begin
                        m_busy[p] = 1'b0;
                    end
                end
            end

            // Grant decision in an idle cycle; lay out the whole transaction.
            if (k >= free_at) begin
                pick = -1;
                for (int i = 1; i <= NP; i++) begin
                    if (pick < 0 && m_busy[(m_last + i) % NP]) pick = (m_last + i) % NP;
                end
                if (pick >= 0) begin
                    m_last = pick;
                    c = k + 1;
                    if (m_wb[pick]) begin
                        exp_wr[c] = 1'b1;
                        exp_maddr[c] = m_waddr[pick];
                        exp_mdata[c] = m_wdata[pick];
                        d = int'($urandom_range(1, 3));
                        drv_rdy[c+d] = 1'b1;
                        drv_data[c+d] = rnd128();
                        c = c + d + 1;
                    end
                    exp_rd[c] = 1'b1;
                    exp_maddr[c] = m_addr[pick];
                    d = int'($urandom_range(1, 3));
                    drv_rdy[c+d] = 1'b1;
                    drv_data[c+d] = rnd128();
                    exp_resp[c+d+1] = pick;
                    exp_rdata[c+d+1] = drv_data[c+d];
                    exp_raddr[c+d+1] = m_addr[pick];
                    for (int j = k + 1; j <= c + d; j++) nostray[j] = 1'b1;
                    free_at = c + d + 2;
                end
            end

            for (int p = 0; p < NP; p++) mb[p] = m_busy[p];
            er = '0;
            if (exp_resp[k] >= 0) er[exp_resp[k]] = 1'b1;
            chk("busy", busy_o, mb);
            chk("mm_wr", mm_wr_req_o, exp_wr[k]);
            chk("mm_rd", mm_rd_req_o, exp_rd[k]);
            if (exp_wr[k]) begin
                chk("wb_addr", mm_addr_o, exp_maddr[k]);
                chk("wb_data", mm_data_o, exp_mdata[k]);
            end
            if (exp_rd[k]) chk("rd_addr", mm_addr_o, exp_maddr[k]);
            chk("rdy", rdy_o, er);
            if (exp_resp[k] >= 0) begin
                chk("resp_addr", addr_o, exp_raddr[k]);
                chk("resp_data", data_o, exp_rdata[k]);
            end
            chk("req_excl", mm_rd_req_o && mm_wr_req_o, 0);
            chk("rdy_onehot", $countones(rdy_o) <= 1, 1);

            // Memory pulses: scheduled ones, plus strays where they must be ignored.
            mm_data_rdy_i = drv_rdy[k];
            mm_data_i = drv_rdy[k] ? drv_data[k] : rnd128();
            if (!drv_rdy[k] && !nostray[k] && $urandom_range(0, 7) == 0) mm_data_rdy_i = 1'b1;
            for (int p = 0; p < NP; p++) begin
                miss_i[p] = ($urandom_range(0, 3) == 0);
                wb_i[p] = $urandom_range(0, 1) == 1;
                miss_addr_i[p*AW +: AW] = $urandom;
                wb_addr_i[p*AW +: AW] = $urandom;
                wb_data_i[p*LW +: LW] = rnd128();
            end
            if (k == 0) begin
                miss_i = '1;
                wb_i = 2'b10;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
